// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU add/subtract datapath: FSM states, rounding
// modes, canonical special values and exponent helpers.
package fpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } fsm_state_t;

   typedef enum logic [1:0] {
      RM_NEAREST = 2'b00,
      RM_ZERO    = 2'b01,
      RM_POS_INF = 2'b10,
      RM_NEG_INF = 2'b11
   } rmode_t;

   localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
   localparam logic [63:0] QNAN_DP = 64'h7FF8_0000_0000_0000;
   localparam logic [31:0] INF_SP  = 32'h7F80_0000;
   localparam logic [63:0] INF_DP  = 64'h7FF0_0000_0000_0000;

   function automatic int unsigned exp_bias(input int unsigned ew);
      return (32'd1 << (ew - 1)) - 1;
   endfunction

endpackage

// File: rtl/fpu_add_subtract_function_if.sv
// Start/ready/acknowledge handshake plus operand and result bus of the
// FPU add/subtract unit.
interface fpu_add_subtract_function_if #(
   parameter int W = 32
);
   logic         beg_FSM;
   logic         ack_FSM;
   logic [W-1:0] Data_X;
   logic [W-1:0] Data_Y;
   logic         add_subt;
   logic [1:0]   r_mode;
   logic         overflow_flag;
   logic         underflow_flag;
   logic         ready;
   logic [W-1:0] final_result_ieee;

   modport master (
      output beg_FSM, ack_FSM, Data_X, Data_Y, add_subt, r_mode,
      input  overflow_flag, underflow_flag, ready, final_result_ieee
   );

   modport slave (
      input  beg_FSM, ack_FSM, Data_X, Data_Y, add_subt, r_mode,
      output overflow_flag, underflow_flag, ready, final_result_ieee
   );
endinterface

// File: rtl/fpu_lzc_shift.sv
// Leading-zero counter with matching left barrel shift; an all-zero input
// reports a count of SWR.
module fpu_lzc_shift #(
   parameter int SWR = 26,
   parameter int EWR = 5
) (
   input  logic [SWR-1:0] sig,
   output logic [EWR-1:0] count,
   output logic [SWR-1:0] shifted
);

   always_comb begin
      count = EWR'(SWR);
      for (int unsigned i = 0; i < SWR; i++) begin
         if (sig[i]) count = EWR'(SWR - 1 - i);
      end
      shifted = sig << count;
   end

endmodule

// File: rtl/fpu_add_subtract_function.sv
// Multi-cycle IEEE-754 adder/subtractor: ALIGN, ADD, NORM and ROUND steps
// behind a beg/ready/ack handshake, subnormals flushed to zero.
module fpu_add_subtract_function
   import fpu_pkg::*;
#(
   parameter int W   = 32,
   parameter int EW  = 8,
   parameter int SW  = 23,
   parameter int SWR = 26,
   parameter int EWR = 5
) (
   input logic                        clk,
   input logic                        rst,
   fpu_add_subtract_function_if.slave bus
);

   localparam logic [W-1:0]         QNAN     = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
   localparam logic signed [EW+1:0] EXP_INF  = (EW+2)'(2 * exp_bias(EW) + 1);
   localparam logic signed [EW+1:0] EXP_ONE  = (EW+2)'(1);
   localparam logic signed [EW+1:0] EXP_ZERO = '0;
   localparam logic [EW-1:0]        SWR_E    = EW'(SWR);

   fsm_state_t state, state_nx;

   logic [W-1:0]         x_r, y_r, res_r;
   logic                 sub_r, sign_r, eff_sub_r, stk_r, zero_r;
   logic                 ovf_r, unf_r, ready_r;
   rmode_t               rm_r;
   logic signed [EW+1:0] exp_r;
   logic [SWR-1:0]       siga_r, sigb_r;
   logic [SWR:0]         sum_r;

   // ALIGN
   logic           sx, sy, sa, x_nan, y_nan, x_inf, y_inf, special, x_ge, b_stk;
   logic [EW-1:0]  ex, ey, ea, eb, dexp;
   logic [SWR-1:0] mx, my, ma, mb, mb_sh;
   logic [W-1:0]   special_res;

   always_comb begin
      sx    = x_r[W-1];
      sy    = y_r[W-1] ^ sub_r;
      ex    = x_r[W-2:SW];
      ey    = y_r[W-2:SW];
      mx    = (ex == '0) ? '0 : {1'b1, x_r[SW-1:0], 2'b00};
      my    = (ey == '0) ? '0 : {1'b1, y_r[SW-1:0], 2'b00};
      x_nan = (ex == '1) && (x_r[SW-1:0] != '0);
      y_nan = (ey == '1) && (y_r[SW-1:0] != '0);
      x_inf = (ex == '1) && (x_r[SW-1:0] == '0);
      y_inf = (ey == '1) && (y_r[SW-1:0] == '0);
      special = (ex == '1) || (ey == '1);
      if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) special_res = QNAN;
      else if (x_inf)                                       special_res = {sx, {EW{1'b1}}, {SW{1'b0}}};
      else                                                  special_res = {sy, {EW{1'b1}}, {SW{1'b0}}};
      x_ge = {ex, mx} >= {ey, my};
      ea   = x_ge ? ex : ey;
      eb   = x_ge ? ey : ex;
      ma   = x_ge ? mx : my;
      mb   = x_ge ? my : mx;
      sa   = x_ge ? sx : sy;
      dexp = ea - eb;
      if (dexp >= SWR_E) begin
         mb_sh = '0;
         b_stk = |mb;
      end else begin
         mb_sh = mb >> dexp;
         b_stk = |(mb & ~({SWR{1'b1}} << dexp));
      end
   end

   // ADD: sticky rides as an extra LSB so a subtraction borrows from it and
   // the true "slightly less than" magnitude survives into rounding.
   logic [SWR+1:0] full;
   always_comb begin
      if (eff_sub_r) full = {1'b0, siga_r, 1'b0} - {1'b0, sigb_r, stk_r};
      else           full = {1'b0, siga_r, 1'b0} + {1'b0, sigb_r, stk_r};
   end

   // NORM
   logic [EWR-1:0]       lz_cnt;
   logic [SWR-1:0]       lz_sig, norm_sig;
   logic signed [EW+1:0] norm_exp;
   logic                 norm_stk;

   fpu_lzc_shift #(.SWR(SWR), .EWR(EWR)) u_lzc (
      .sig     (sum_r[SWR-1:0]),
      .count   (lz_cnt),
      .shifted (lz_sig)
   );

   always_comb begin
      if (sum_r[SWR]) begin
         norm_sig = sum_r[SWR:1];
         norm_stk = stk_r | sum_r[0];
         norm_exp = exp_r + EXP_ONE;
      end else begin
         norm_sig = lz_sig;
         norm_stk = stk_r;
         norm_exp = exp_r - $signed({{(EW+2-EWR){1'b0}}, lz_cnt});
      end
   end

   // ROUND
   logic [SW:0]          mant;
   logic [SW+1:0]        mant_rnd;
   logic [SW-1:0]        frac;
   logic                 g, rs, inc, rnd_ovf, rnd_unf;
   logic signed [EW+1:0] exp_rnd;
   logic [W-1:0]         rnd_res;

   always_comb begin
      mant = siga_r[SWR-1:2];
      g    = siga_r[1];
      rs   = siga_r[0] | stk_r;
      inc  = 1'b0;
      case (rm_r)
         RM_NEAREST: inc = g & (rs | mant[0]);
         RM_ZERO:    inc = 1'b0;
         RM_POS_INF: inc = ~sign_r & (g | rs);
         RM_NEG_INF: inc = sign_r & (g | rs);
         default:    inc = 1'b0;
      endcase
      mant_rnd = {1'b0, mant} + {{(SW+1){1'b0}}, inc};
      frac     = mant_rnd[SW+1] ? mant_rnd[SW:1] : mant_rnd[SW-1:0];
      exp_rnd  = mant_rnd[SW+1] ? exp_r + EXP_ONE : exp_r;
      rnd_ovf  = 1'b0;
      rnd_unf  = 1'b0;
      if (zero_r) begin
         rnd_res = {(rm_r == RM_NEG_INF), {(W-1){1'b0}}};
      end else if (exp_rnd >= EXP_INF) begin
         rnd_res = {sign_r, {EW{1'b1}}, {SW{1'b0}}};
         rnd_ovf = 1'b1;
      end else if (exp_rnd <= EXP_ZERO) begin
         rnd_res = {sign_r, {(W-1){1'b0}}};
         rnd_unf = 1'b1;
      end else begin
         rnd_res = {sign_r, exp_rnd[EW-1:0], frac};
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.beg_FSM) state_nx = S_ALIGN;
         S_ALIGN: state_nx = special ? S_DONE : S_ADD;
         S_ADD:   state_nx = S_NORM;
         S_NORM:  state_nx = S_ROUND;
         S_ROUND: state_nx = S_DONE;
         S_DONE:  if (ready_r && bus.ack_FSM) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_r       <= '0;
         y_r       <= '0;
         sub_r     <= 1'b0;
         rm_r      <= RM_NEAREST;
         sign_r    <= 1'b0;
         eff_sub_r <= 1'b0;
         exp_r     <= '0;
         siga_r    <= '0;
         sigb_r    <= '0;
         stk_r     <= 1'b0;
         sum_r     <= '0;
         zero_r    <= 1'b0;
         res_r     <= '0;
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
         ready_r   <= 1'b0;
      end else begin
         // ready rises one edge after DONE is entered and drops on the ack edge
         ready_r <= (state == S_DONE) && !(ready_r && bus.ack_FSM);
         case (state)
            S_IDLE: if (bus.beg_FSM) begin
               x_r   <= bus.Data_X;
               y_r   <= bus.Data_Y;
               sub_r <= bus.add_subt;
               rm_r  <= rmode_t'(bus.r_mode);
               ovf_r <= 1'b0;
               unf_r <= 1'b0;
            end
            S_ALIGN: begin
               if (special) res_r <= special_res;
               sign_r    <= sa;
               eff_sub_r <= sx ^ sy;
               exp_r     <= {2'b00, ea};
               siga_r    <= ma;
               sigb_r    <= mb_sh;
               stk_r     <= b_stk;
            end
            S_ADD: begin
               sum_r  <= full[SWR+1:1];
               stk_r  <= full[0];
               zero_r <= (full == '0);
            end
            S_NORM: begin
               siga_r <= norm_sig;
               stk_r  <= norm_stk;
               exp_r  <= norm_exp;
            end
            S_ROUND: begin
               res_r <= rnd_res;
               ovf_r <= rnd_ovf;
               unf_r <= rnd_unf;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready             = ready_r;
   assign bus.final_result_ieee = res_r;
   assign bus.overflow_flag     = ovf_r;
   assign bus.underflow_flag    = unf_r;

endmodule

// File: tb/tb_fpu_add_subtract_function.sv
// Bench for the single-precision adder/subtractor: fixed vectors, handshake
// corner sequences and random operands against an exact big-integer model.
module tb_fpu_add_subtract_function;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fpu_add_subtract_function_if #(.W(32)) bus ();

   fpu_add_subtract_function #(.W(32), .EW(8), .SW(23), .SWR(26), .EWR(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        sub;
      logic [1:0]  rm;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
   } vec_t;

   typedef struct packed {
      logic        spec;
      logic        ovf;
      logic        unf;
      logic [31:0] res;
   } ref_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Exact sum of the two operands as integers in units of 2^-149, then one
   // rounding to 24 significant bits and a range check of the exponent.
   function automatic ref_t ref_model(input logic [31:0] x, input logic [31:0] y,
                                      input logic sub, input logic [1:0] rm);
      ref_t         r;
      logic         sx, sy, s, inc;
      int           ex, ey, p, sh, e;
      logic [299:0] mx, my, mag, keep, rem, half;
      r  = '0;
      sx = x[31];
      sy = y[31] ^ sub;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      if (ex == 255 || ey == 255) begin
         r.spec = 1'b1;
         if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
             (ex == 255 && ey == 255 && sx != sy)) r.res = 32'h7FC00000;
         else if (ex == 255)                      r.res = {sx, 8'hFF, 23'h0};
         else                                     r.res = {sy, 8'hFF, 23'h0};
         return r;
      end
      mx = (ex == 0) ? '0 : (300'({1'b1, x[22:0]}) << (ex - 1));
      my = (ey == 0) ? '0 : (300'({1'b1, y[22:0]}) << (ey - 1));
      if (sx == sy)      begin mag = mx + my; s = sx; end
      else if (mx >= my) begin mag = mx - my; s = sx; end
      else               begin mag = my - mx; s = sy; end
      if (mag == 0) begin
         r.res = {(rm == 2'b11), 31'h0};
         return r;
      end
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      sh = p - 23;
      e  = sh + 1;
      if (sh > 0) begin
         keep = mag >> sh;
         rem  = mag - (keep << sh);
         half = 300'(1) << (sh - 1);
         case (rm)
            2'b00:   inc = (rem > half) || (rem == half && keep[0]);
            2'b10:   inc = !s && (rem != 0);
            2'b11:   inc = s && (rem != 0);
            default: inc = 1'b0;
         endcase
         keep = keep + 300'(inc);
         if (keep[24]) begin
            keep = keep >> 1;
            e++;
         end
      end else begin
         keep = mag << (-sh);
      end
      if (e >= 255) begin
         r.ovf = 1'b1;
         r.res = {s, 8'hFF, 23'h0};
      end else if (e <= 0) begin
         r.unf = 1'b1;
         r.res = {s, 31'h0};
      end else begin
         r.res = {s, 8'(e), keep[22:0]};
      end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge where ready is seen (or timeout).
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sub,
                         input logic [1:0] rm, output logic [31:0] res,
                         output logic ovf, output logic unf, output int lat);
      bus.Data_X   = x;
      bus.Data_Y   = y;
      bus.add_subt = sub;
      bus.r_mode   = rm;
      bus.beg_FSM  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.beg_FSM = 1'b0;
      lat = 0;
      while (!bus.ready && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      res = bus.final_result_ieee;
      ovf = bus.overflow_flag;
      unf = bus.underflow_flag;
   endtask

   task automatic do_ack(input string name);
      bus.ack_FSM = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ack_FSM = 1'b0;
      check({name, "_ready_low"}, 64'(bus.ready), 64'd0);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   vec_t        tbl[16];
   logic [31:0] res, x, y;
   logic        ovf, unf, sub;
   logic [1:0]  rm;
   int          lat;
   ref_t        rf;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      bus.beg_FSM  = 1'b0;
      bus.ack_FSM  = 1'b0;
      bus.Data_X   = '0;
      bus.Data_Y   = '0;
      bus.add_subt = 1'b0;
      bus.r_mode   = 2'b00;

      tbl[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 1'b0, 1'b0, 5};
      tbl[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 32'h00000000, 1'b0, 1'b0, 5};
      tbl[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 32'h80000000, 1'b0, 1'b0, 5};
      tbl[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 1'b1, 1'b0, 5};
      tbl[4]  = '{32'h00800001, 32'h00800000, 1'b1, 2'b00, 32'h00000000, 1'b0, 1'b1, 5};
      tbl[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 1'b0, 1'b0, 5};
      tbl[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 2'b01, 32'h3F800000, 1'b0, 1'b0, 5};
      tbl[7]  = '{32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 1'b0, 1'b0, 5};
      tbl[8]  = '{32'h3F800000, 32'h33000000, 1'b1, 2'b01, 32'h3F7FFFFF, 1'b0, 1'b0, 5};
      tbl[9]  = '{32'h3F800000, 32'h33000000, 1'b1, 2'b00, 32'h3F800000, 1'b0, 1'b0, 5};
      tbl[10] = '{32'hC0400000, 32'h3F800000, 1'b0, 2'b00, 32'hC0000000, 1'b0, 1'b0, 5};
      tbl[11] = '{32'h00000001, 32'h3F800000, 1'b0, 2'b00, 32'h3F800000, 1'b0, 1'b0, 5};
      tbl[12] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 2'b00, 32'h7F800000, 1'b1, 1'b0, 5};
      tbl[13] = '{32'h7FC00001, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 1'b0, 1'b0, 2};
      tbl[14] = '{32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000, 1'b0, 1'b0, 2};
      tbl[15] = '{32'h3F800000, 32'h7F800000, 1'b1, 2'b00, 32'hFF800000, 1'b0, 1'b0, 2};

      repeat (3) @(negedge clk);
      check("rst_ready", 64'(bus.ready), 64'd0);
      check("rst_result", 64'(bus.final_result_ieee), 64'd0);
      check("rst_ovf", 64'(bus.overflow_flag), 64'd0);
      check("rst_unf", 64'(bus.underflow_flag), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         run_op(tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].rm, res, ovf, unf, lat);
         check($sformatf("vec%0d_res", i), 64'(res), 64'(tbl[i].res));
         check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
         check($sformatf("vec%0d_unf", i), 64'(unf), 64'(tbl[i].unf));
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
         do_ack($sformatf("vec%0d", i));
      end

      // ready and result held while ack stays low
      run_op(32'h3F800000, 32'h40000000, 1'b0, 2'b00, res, ovf, unf, lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("hold%0d_ready", i), 64'(bus.ready), 64'd1);
         check($sformatf("hold%0d_res", i), 64'(bus.final_result_ieee), 64'h40400000);
      end
      do_ack("hold");

      // beg pulsed while the operation is in ADD is ignored
      bus.Data_X = 32'h3F800000; bus.Data_Y = 32'h40000000;
      bus.add_subt = 1'b0; bus.r_mode = 2'b00; bus.beg_FSM = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.beg_FSM = 1'b0;
      @(posedge clk); @(negedge clk);
      bus.Data_X = 32'h40800000; bus.beg_FSM = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.beg_FSM = 1'b0;
      lat = 2;
      while (!bus.ready && lat < 40) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      check("busy_beg_lat", 64'(lat), 64'd5);
      check("busy_beg_res", 64'(bus.final_result_ieee), 64'h40400000);
      do_ack("busy_beg");
      wait_cycles(7);
      check("busy_beg_no_restart", 64'(bus.ready), 64'd0);

      // ack and beg together in DONE: ack wins, beg dropped
      run_op(32'h40000000, 32'h3F800000, 1'b1, 2'b00, res, ovf, unf, lat);
      check("ackbeg_res", 64'(res), 64'h3F800000);
      bus.Data_X = 32'h40800000; bus.ack_FSM = 1'b1; bus.beg_FSM = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.ack_FSM = 1'b0; bus.beg_FSM = 1'b0;
      check("ackbeg_ready_low", 64'(bus.ready), 64'd0);
      wait_cycles(7);
      check("ackbeg_no_start", 64'(bus.ready), 64'd0);

      // reset asserted while the operation is in NORM
      bus.Data_X = 32'h3F800000; bus.Data_Y = 32'h40000000;
      bus.add_subt = 1'b0; bus.r_mode = 2'b00; bus.beg_FSM = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.beg_FSM = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_ready", 64'(bus.ready), 64'd0);
      check("midrst_res", 64'(bus.final_result_ieee), 64'd0);
      check("midrst_ovf", 64'(bus.overflow_flag), 64'd0);
      check("midrst_unf", 64'(bus.underflow_flag), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, res, ovf, unf, lat);
      check("postrst_res", 64'(res), 64'h7F800000);
      check("postrst_ovf", 64'(ovf), 64'd1);
      check("postrst_lat", 64'(lat), 64'd5);
      do_ack("postrst");

      for (int i = 0; i < 300; i++) begin
         x = $urandom;
         y = $urandom;
         if (i % 2 == 0) y[30:23] = x[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
         if (i % 7 == 0) y[30:23] = x[30:23] - 8'($urandom_range(20, 30));
         sub = 1'($urandom_range(0, 1));
         rm  = 2'($urandom_range(0, 3));
         rf  = ref_model(x, y, sub, rm);
         run_op(x, y, sub, rm, res, ovf, unf, lat);
         check($sformatf("rnd%0d_res x=%h y=%h s=%0d rm=%0d", i, x, y, sub, rm), 64'(res), 64'(rf.res));
         check($sformatf("rnd%0d_ovf", i), 64'(ovf), 64'(rf.ovf));
         check($sformatf("rnd%0d_unf", i), 64'(unf), 64'(rf.unf));
         check($sformatf("rnd%0d_lat", i), 64'(lat), rf.spec ? 64'd2 : 64'd5);
         do_ack($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_add_subtract_function.md
# fpu_add_subtract_function

Multi-cycle IEEE-754 binary floating-point adder/subtractor, parameterised for single (default) or double precision. Sits behind an FSM-driven start/ready/acknowledge handshake in the FPU datapath. Captures two operands and an operation select, then produces a rounded IEEE result with overflow and underflow flags.

## Interface
- W, 32: total word width (64 for double).
- EW, 8: exponent width (11 for double).
- SW, 23: stored fraction width (52 for double).
- SWR, 26: internal significand width, SW+3 (hidden bit, SW fraction bits, guard, round); sticky is kept as a separate bit.
- EWR, 5: alignment/normalisation shift-count width, ceil(log2(SWR)) (6 for double).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- beg_FSM  in  1  start request; sampled only in IDLE.
- ack_FSM  in  1  result acknowledge; sampled only in DONE.
- Data_X  in  W  operand X (IEEE).
- Data_Y  in  W  operand Y (IEEE).
- add_subt  in  1  0 = X+Y, 1 = X−Y.
- r_mode  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward −inf.
- overflow_flag  out  1  result overflowed.
- underflow_flag  out  1  result underflowed (flushed).
- ready  out  1  result and flags valid.
- final_result_ieee  out  W  IEEE result.

## Operation
- FSM states: IDLE → ALIGN → ADD → NORM → ROUND → DONE → IDLE.
- IDLE: if beg_FSM=1, register Data_X, Data_Y, add_subt and r_mode, clear both flags, and go to ALIGN. Inputs are ignored in all other states.
- ALIGN:
  - Unpack both operands; Y's sign is inverted when add_subt=1.
  - Subnormal inputs (exponent 0) are treated as signed zero.
  - Swap operands so the larger magnitude is A.
  - Right-shift B's significand by the exponent difference, ORing every bit shifted out into sticky.
  - A shift of SWR or more leaves B as sticky only.
- ADD:
  - Effective add or subtract of the significands in SWR+1 bits.
  - Result sign is A's sign.
  - Exact zero result: +0, except −0 when r_mode=11.
- NORM:
  - Carry-out: shift right 1 (LSB into sticky), exponent +1.
  - Otherwise: left-shift by the leading-zero count, exponent − count.
- ROUND:
  - Apply r_mode using guard, round and sticky.
  - A carry from rounding renormalises: shift right 1, exponent +1.
  - Pack the result; go to DONE.
- Exponent handling:
  - Biased exponent ≥ 2^EW−1 → ±inf, overflow_flag=1.
  - Biased exponent ≤ 0 → signed zero, underflow_flag=1.
  - Exponent arithmetic is done in EW+2 signed bits so neither case wraps.
- Special operands (exponent all ones), resolved in ALIGN and passed straight through to DONE:
  - Any NaN → 0x7FC00000 (canonical qNaN; double 0x7FF8000000000000).
  - inf − inf (effective) → canonical qNaN.
  - inf ± finite → that inf.
  - Flags stay 0 in all these cases.
- DONE: ready=1; result and flags are held. ack_FSM=1 → IDLE.
- final_result_ieee and the flags keep their last value after DONE until the next operation clears the flags in IDLE.

## Timing
- Reset (asynchronous, active-low): state IDLE, ready=0, final_result_ieee=0, overflow_flag=0, underflow_flag=0. Reset mid-operation aborts immediately with no output.
- Latency: beg_FSM sampled at edge k → ready=1 after edge k+5. ready is registered.
- ready stays high indefinitely until ack_FSM is sampled high in DONE; it falls after that edge.
- beg_FSM while busy or in DONE is ignored. ack_FSM and beg_FSM together in DONE: ack wins, beg is dropped.
- A new operation can start on the first edge after returning to IDLE.

## Structure
- Package fpu_pkg:
  - FSM state enum.
  - r_mode encodings.
  - Canonical qNaN / inf constants per width.
  - Helper functions for bias (2^(EW−1)−1).
- One sub-module: fpu_lzc_shift, a combinational leading-zero counter plus left barrel shifter over SWR bits, returning the count (EWR bits) and the shifted significand.

## Test plan
- 0x3F800000 + 0x40000000, add_subt=0, r_mode=00 → 0x40400000; ready exactly 5 edges after beg; flags 0.
- 0x3F800000 − 0x3F800000 → 0x00000000 with r_mode=00; → 0x80000000 with r_mode=11.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow_flag=1.
- 0x00800001 − 0x00800000 → 0x00000000, underflow_flag=1.
- 0x3F800000 + 0x33800000 → 0x3F800000 (r_mode 00 and 01), 0x3F800001 (r_mode 10).
- Handshake:
  - Hold ack_FSM low for 10 cycles → ready and result stable.
  - beg_FSM pulsed during ADD → ignored.
  - rst low during NORM → ready=0 and outputs 0 immediately, next op correct.
